fir_serial_mac: RTL and testbench
=================================

# fir_serial_mac

Parametrised, time-multiplexed FIR filter that replaces the fixed 63-tap, fully parallel filter stage with a single signed multiply-accumulate unit iterated over all taps. It adds valid/ready handshakes on input and output, run-time loadable coefficients, rounding, and output saturation. It sits in the same sample-processing chain: upstream sample source → fir_serial_mac → downstream consumer.

## Interface
- DW, 16: input sample width, signed.
- CW, 8: coefficient width, signed.
- TAPS, 63: number of taps, ≥2.
- OW, 24: output width, signed.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.
- COEF_INIT, {coef0=1, others 0}: CW*TAPS-bit vector of reset coefficients; coef k occupies bits [CW*k +: CW].
- AW, derived: clog2(TAPS).
- ACCW, derived: DW+CW+clog2(TAPS).
- clk  in  1  clock.
- rst_p  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DW  signed input sample.
- out_valid  out  1  filtered result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OW  signed filtered result.
- out_sat  out  1  out_data was clipped; qualified by out_valid.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW  coefficient index k.
- coef_wdata  in  CW  signed coefficient value.

## Operation
- FSM states: IDLE, MAC, OUT. Reset enters IDLE.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_sat=0. All TAPS history samples are 0, the write pointer is 0, the accumulator is 0, and the coefficients equal COEF_INIT.
- IDLE: in_ready=1. When in_valid is high:
  - write in_data to history[wr_ptr];
  - clear the accumulator and the tap index k;
  - go to MAC.
- MAC, one tap per cycle for k = 0..TAPS-1:
  - acc += history[(wr_ptr − k) mod TAPS] × coef[k];
  - operands are sign-extended to ACCW;
  - wrap-around is modulo TAPS, not modulo 2^AW.
- After k = TAPS-1:
  - advance wr_ptr, wrapping from TAPS-1 to 0;
  - register the result;
  - go to OUT.
- Result computation:
  - r = (acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, which rounds half-up;
  - if r > 2^(OW-1)-1, output that value with out_sat=1;
  - if r < -2^(OW-1), output that value with out_sat=1;
  - otherwise output r with out_sat=0.
- OUT: out_valid=1, and out_data/out_sat are held stable until out_valid && out_ready. On that cycle, return to IDLE; out_valid goes to 0 on the next edge.
- Coefficient writes:
  - take effect on the clock edge only while the FSM is in IDLE, and are visible to the next accepted sample;
  - coef_we in MAC or OUT is ignored (dropped, no error flag);
  - coef_addr ≥ TAPS is ignored.
- A coefficient write and an input sample in the same IDLE cycle: both are performed, and the new coefficient is used for that sample.
- rst_p asserted mid-MAC or in OUT aborts immediately to the reset state. The partial result is discarded and the history is cleared.

## Timing
- Sample accepted at edge T0 (in_valid && in_ready).
- MAC occupies edges T0+1 … T0+TAPS.
- out_valid rises after edge T0+TAPS+1, so latency is TAPS+1 cycles.
- With out_ready held high, in_ready returns after edge T0+TAPS+2. Throughput is 1 sample per TAPS+2 cycles.
- in_ready is 0 throughout MAC and OUT; in_data is not sampled there.
- The multiply-accumulate is single-cycle and combinational inside MAC; no multiplier pipeline.

## Structure
- Package fir_pkg holds:
  - the state enum (IDLE/MAC/OUT);
  - a clog2 function;
  - saturation/rounding helper functions parameterised on ACCW/OW.
- Sub-module fir_coef_bank: TAPS×CW register file with asynchronous reset to COEF_INIT, one write port gated by an enable, one combinational read port.
- History buffer and FSM stay in fir_serial_mac.

## Test plan
- Impulse response, defaults (TAPS=63, COEF_INIT), one coefficient set: load coefficients k = 0..62 = 1..63, then feed 1000 followed by 62 zeros. out_data must be 1000×(k+1), k = 0..62, in order.
- Saturation with TAPS=63, SHIFT=0, OW=24, all coefficients 127, inputs 32767 repeated 63 times. The final outputs are clipped to 8388607 with out_sat=1; the first output is 4161409 with out_sat=0.
- Rounding with SHIFT=2 and coef0=1, others 0:
  - input 6 → out 2;
  - input 5 → out 1;
  - input −6 → out −1;
  - all with out_sat=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. out_data must stay stable, in_ready must stay 0, and one result is delivered when out_ready rises.
- Coefficient write while busy: coef_we to k=0 with value 5 during MAC is ignored, so the output still uses the old coef0. The same write in IDLE takes effect on the next sample.
- Reset mid-MAC: assert rst_p at cycle T0+20. Outputs go to their reset values. The next sample 100 with COEF_INIT outputs 100, with no contribution from pre-reset history.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the serial-MAC FIR filter.
// Helpers work on 64-bit signed values so any ACCW/OW up to 64 bits fits.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } sat_res_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Half-up rounding: add half an LSB of the shifted result, then shift arithmetically.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] acc,
                                                       input int                 shift);
        logic signed [63:0] bias;
        bias = (shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
        return (acc + bias) >>> shift;
    endfunction

    function automatic sat_res_t saturate(input logic signed [63:0] r, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           res;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        res.sat = 1'b0;
        res.val = r;
        if (r > hi) begin
            res.sat = 1'b1;
            res.val = hi;
        end else if (r < lo) begin
            res.sat = 1'b1;
            res.val = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// TAPS x CW coefficient register file: async reset to COEF_INIT,
// one enabled write port, one combinational read port.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int                  CW        = 8,
    parameter int                  TAPS      = 63,
    parameter int                  AW        = 6,
    parameter logic [CW*TAPS-1:0]  COEF_INIT = '0
) (
    input  logic                 clk,
    input  logic                 rst_p,
    input  logic                 wr_en,
    input  logic [AW-1:0]        waddr,
    input  logic signed [CW-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic signed [CW-1:0] rdata
);

    localparam logic [AW:0] TAPS_W = (AW + 1)'(TAPS);

    logic signed [CW-1:0] coef [TAPS];

    // Addresses past the last tap are silently dropped on write and read as zero.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            for (int i = 0; i < TAPS; i++) coef[i] <= COEF_INIT[CW*i +: CW];
        end else if (wr_en && ({1'b0, waddr} < TAPS_W)) begin
            coef[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < TAPS_W) ? coef[raddr] : '0;

endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR: one signed MAC iterated over all taps per sample,
// valid/ready on both sides, runtime coefficients, rounding and saturation.
module fir_serial_mac
    import fir_pkg::*;
#(
    parameter int                 DW        = 16,
    parameter int                 CW        = 8,
    parameter int                 TAPS      = 63,
    parameter int                 OW        = 24,
    parameter int                 SHIFT     = 0,
    parameter logic [CW*TAPS-1:0] COEF_INIT = {{(CW*TAPS-1){1'b0}}, 1'b1},
    localparam int                AW        = clog2(TAPS),
    localparam int                ACCW      = DW + CW + clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 rst_p,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data,
    output logic                 out_sat,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_wdata
);

    localparam logic [AW:0] TAPS_W = (AW + 1)'(TAPS);

    state_t                 state;
    state_t                 state_next;
    logic signed [DW-1:0]   hist [TAPS];
    logic [AW-1:0]          wr_ptr;
    logic [AW:0]            k;
    logic signed [ACCW-1:0] acc;
    logic [AW:0]            rd_sum;
    logic [AW-1:0]          rd_idx;
    logic signed [CW-1:0]   coef_rd;
    logic signed [ACCW-1:0] prod;
    sat_res_t               res;
    logic                   accept;
    logic                   mac_done;
    logic                   unused_bits;

    // Handshake: a transfer happens on an edge where valid && ready; the result holds until taken.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign accept    = in_valid && in_ready;
    assign mac_done  = (state == MAC) && (k == TAPS_W);

    fir_coef_bank #(
        .CW        (CW),
        .TAPS      (TAPS),
        .AW        (AW),
        .COEF_INIT (COEF_INIT)
    ) u_coef_bank (
        .clk   (clk),
        .rst_p (rst_p),
        .wr_en (coef_we && (state == IDLE)),
        .waddr (coef_addr),
        .wdata (coef_wdata),
        .raddr (k[AW-1:0]),
        .rdata (coef_rd)
    );

    // Newest sample sits at wr_ptr; tap k walks backwards, wrapping modulo TAPS.
    always_comb begin
        rd_sum = ({1'b0, wr_ptr} >= k) ? ({1'b0, wr_ptr} - k)
                                       : ({1'b0, wr_ptr} + TAPS_W - k);
        rd_idx = rd_sum[AW-1:0];
        prod   = ACCW'(hist[rd_idx]) * ACCW'(coef_rd);
        res    = saturate(round_shift(64'(acc), SHIFT), OW);
    end

    assign unused_bits = ^{res.val[63:OW], rd_sum[AW]};

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = MAC;
            MAC:     if (mac_done)  state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // k runs 0..TAPS-1 accumulating; the extra k==TAPS cycle registers the result.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            for (int i = 0; i < TAPS; i++) hist[i] <= '0;
            wr_ptr   <= '0;
            k        <= '0;
            acc      <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (accept) begin
            hist[wr_ptr] <= in_data;
            acc          <= '0;
            k            <= '0;
        end else if (mac_done) begin
            out_data <= res.val[OW-1:0];
            out_sat  <= res.sat;
            wr_ptr   <= ({1'b0, wr_ptr} == TAPS_W - 1'b1) ? '0 : wr_ptr + 1'b1;
        end else if (state == MAC) begin
            acc <= acc + prod;
            k   <= k + 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: default instance plus a SHIFT=2 instance sharing stimulus,
// both compared against a sum-of-products reference over a sample history queue.
module tb_fir_serial_mac;

    localparam int DW   = 16;
    localparam int CW   = 8;
    localparam int TAPS = 63;
    localparam int OW   = 24;
    localparam int AW   = 6;

    logic                 clk = 1'b0;
    logic                 rst_p;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic                 out_sat;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_wdata;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic signed [OW-1:0] out_data_r;
    logic                 out_sat_r;

    int     total = 0;
    int     bad   = 0;
    int     mcoef [TAPS];
    longint mhist [$];

    typedef struct {
        int din;
        int exp_r;
    } rnd_vec_t;

    always #5 clk = ~clk;

    fir_serial_mac dut (
        .clk        (clk),
        .rst_p      (rst_p),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata)
    );

    fir_serial_mac #(.SHIFT(2)) dut_r (
        .clk        (clk),
        .rst_p      (rst_p),
        .in_valid   (in_valid),
        .in_ready   (in_ready_r),
        .in_data    (in_data),
        .out_valid  (out_valid_r),
        .out_ready  (out_ready),
        .out_data   (out_data_r),
        .out_sat    (out_sat_r),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata)
    );

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic model_reset();
        mhist.delete();
        for (int i = 0; i < TAPS; i++) begin
            mhist.push_back(0);
            mcoef[i] = 0;
        end
        mcoef[0] = 1;
    endtask

    // y = sum over taps of (k-th newest sample * coef k), then round and clip.
    task automatic model_out(input int shift, output longint val, output bit sat);
        longint acc;
        longint r;
        acc = 0;
        for (int i = 0; i < TAPS; i++) acc += mhist[i] * mcoef[i];
        r = acc;
        if (shift > 0) r = (acc + (longint'(1) << (shift - 1))) >>> shift;
        sat = 1'b0;
        val = r;
        if (r > 64'sd8388607) begin
            val = 8388607;
            sat = 1'b1;
        end else if (r < -64'sd8388608) begin
            val = -8388608;
            sat = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_p     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_wdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        rst_p = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we    = 1'b1;
        coef_addr  = AW'(addr);
        coef_wdata = CW'(val);
        @(posedge clk); #1;
        coef_we = 1'b0;
        if (addr < TAPS) mcoef[addr] = val;
    endtask

    task automatic send_sample(input int x, input int hold, input bit poke,
                               input bit same_we, input int same_addr, input int same_val,
                               output logic signed [OW-1:0] got);
        int                   n;
        longint               e0;
        longint               e2;
        bit                   s0;
        bit                   s2;
        logic signed [OW-1:0] held;
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) timeout("in_ready_wait");
        out_ready = (hold == 0);
        in_data   = DW'(x);
        in_valid  = 1'b1;
        if (same_we) begin
            coef_we    = 1'b1;
            coef_addr  = AW'(same_addr);
            coef_wdata = CW'(same_val);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        in_data  = DW'($urandom);
        if (same_we && same_addr < TAPS) mcoef[same_addr] = same_val;
        mhist.push_front(longint'(x));
        void'(mhist.pop_back());
        model_out(0, e0, s0);
        model_out(2, e2, s2);
        check("in_ready_busy", in_ready, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (poke && n >= 5) begin
                coef_we    = 1'b1;
                coef_addr  = '0;
                coef_wdata = 8'sd5;
            end
        end
        coef_we = 1'b0;
        if (n >= 300) timeout("out_valid_wait");
        else check("latency", n, TAPS + 1);
        got = out_data;
        check("out_data", out_data, e0);
        check("out_sat", out_sat, s0);
        check("out_data_shift2", out_data_r, e2);
        check("out_sat_shift2", out_sat_r, s2);
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, held);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    task automatic send(input int x, output logic signed [OW-1:0] got);
        send_sample(x, 0, 1'b0, 1'b0, 0, 0, got);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rnd_vec_t             rv [8];
        logic signed [OW-1:0] got;
        int                   n;
        int                   x;

        rv[0] = '{6, 2};   rv[1] = '{5, 1};   rv[2] = '{-6, -1}; rv[3] = '{7, 2};
        rv[4] = '{-5, -1}; rv[5] = '{-7, -2}; rv[6] = '{2, 1};   rv[7] = '{-2, 0};

        do_reset();

        // Rounding (SHIFT=2 instance) and pass-through (default instance) under COEF_INIT.
        for (int i = 0; i < 8; i++) begin
            send(rv[i].din, got);
            check("rnd_table", out_data_r, rv[i].exp_r);
            check("rnd_sat", out_sat_r, 0);
            check("pass_table", got, rv[i].din);
        end

        // Coefficient writes while busy are dropped; in IDLE they land; same-cycle write applies.
        send_sample(7, 0, 1'b1, 1'b0, 0, 0, got);
        check("busy_write_ignored", got, 7);
        write_coef(0, 5);
        send(3, got);
        check("idle_write_applied", got, 15);
        send_sample(4, 0, 1'b0, 1'b1, 0, 2, got);
        check("same_cycle_write", got, 8);
        write_coef(63, 9);
        send(1, got);
        check("addr_out_of_range", got, 2);

        // Backpressure: result held for 10 cycles then delivered once.
        send_sample(11, 10, 1'b0, 1'b0, 0, 0, got);
        check("backpressure_data", got, 22);

        // Impulse response with coefficients 1..63.
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
        for (int i = 0; i < TAPS; i++) begin
            send((i == 0) ? 1000 : 0, got);
            check("impulse", got, 1000 * (i + 1));
        end

        // Positive saturation.
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(i, 127);
        for (int i = 0; i < TAPS; i++) begin
            send(32767, got);
            if (i == 0) begin
                check("sat_first_data", got, 4161409);
                check("sat_first_flag", out_sat, 0);
            end
        end
        check("sat_last_data", got, 8388607);
        check("sat_last_flag", out_sat, 1);

        // Negative saturation.
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(i, 127);
        for (int i = 0; i < 3; i++) send(-32768, got);
        check("neg_sat_data", got, -8388608);
        check("neg_sat_flag", out_sat, 1);

        // Reset mid-MAC.
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) timeout("mid_reset_ready_wait");
        in_data  = 16'sd200;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("mid_mac_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_p = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        check("abort_out_sat", out_sat, 0);
        @(posedge clk); #1;
        rst_p = 1'b0;
        model_reset();
        @(posedge clk); #1;
        send(100, got);
        check("after_abort", got, 100);

        // Random coefficients and samples with random backpressure.
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(i, int'($urandom_range(0, 255)) - 128);
        for (int i = 0; i < 15; i++) begin
            case ($urandom_range(0, 3))
                0:       x = 32767;
                1:       x = -32768;
                default: x = int'($urandom_range(0, 65535)) - 32768;
            endcase
            send_sample(x, int'($urandom_range(0, 3)), 1'b0, 1'b0, 0, 0, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
